// File: rtl/lcd_pio_strobe.sv
// Purpose: Avalon-MM output port for character-LCD lines with atomic set/clear
//          and a hardware E-strobe sequencer (setup / pulse / hold).
// Latency: register writes take effect on the write edge. Reads are zero-wait combinational.
//          lcd_e rises T_SETUP cycles after a STROBE write.
// Backpressure: there is no wait-request. Output writes issued while busy are dropped and flag overrun.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   address             register select (0 DATA, 1 STATUS, 2 OUTSET, 3 OUTCLR,
//                       4 STROBE, 5 CTRL, 6/7 unmapped)
//   chipselect, write_n write = chipselect & ~write_n
//   writedata/readdata  32-bit slave data. Readdata is zero-extended.
//   out_port            registered LCD RS/RW/data lines
//   lcd_e               registered LCD enable strobe
//   irq                 done & irq_en
module lcd_pio_strobe #(
    parameter int WIDTH   = 6,
    parameter int CNT_W   = 8,
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 12,
    parameter int T_HOLD  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             lcd_e,
    output logic             irq
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_OUTSET = 3'd2;
    localparam logic [2:0] A_OUTCLR = 3'd3;
    localparam logic [2:0] A_STROBE = 3'd4;
    localparam logic [2:0] A_CTRL   = 3'd5;

    // Counters load (duration - 1) so that each phase lasts exactly its duration.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] data_out;
    logic             done;
    logic             overrun;
    logic             irq_en;

    logic             wr;
    logic             busy;
    logic             out_wr;
    logic             out_accept;
    logic             out_reject;
    logic             seq_done;
    logic [WIDTH-1:0] wdat;

    assign wr   = chipselect & ~write_n;
    assign busy = (state != IDLE);
    assign wdat = writedata[WIDTH-1:0];

    // These writes all touch the output lines, so they share the busy lockout.
    assign out_wr     = wr && ((address == A_DATA)   || (address == A_OUTSET) ||
                               (address == A_OUTCLR) || (address == A_STROBE));
    assign out_accept = out_wr && !busy;
    assign out_reject = out_wr && busy;
    assign seq_done   = (state == HOLD) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            lcd_e    <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
            overrun  <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_accept && (address == A_STROBE)) begin
                        state <= SETUP;
                        cnt   <= SETUP_LD;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= PULSE;
                        lcd_e <= 1'b1;
                        cnt   <= PULSE_LD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state <= HOLD;
                        lcd_e <= 1'b0;
                        cnt   <= HOLD_LD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    lcd_e <= 1'b0;
                end
            endcase

            if (out_accept) begin
                case (address)
                    A_DATA:   data_out <= wdat;
                    A_OUTSET: data_out <= data_out | wdat;
                    A_OUTCLR: data_out <= data_out & ~wdat;
                    A_STROBE: data_out <= wdat;
                    default:  data_out <= data_out;
                endcase
            end

            // Clears are written first so that a coincident set overrides them.
            if (wr && (address == A_STATUS)) begin
                if (writedata[1]) overrun <= 1'b0;
                if (writedata[2]) done    <= 1'b0;
            end
            if (out_reject) overrun <= 1'b1;
            if (seq_done)   done    <= 1'b1;

            if (wr && (address == A_CTRL)) irq_en <= writedata[0];
        end
    end

    assign out_port = data_out;
    assign irq      = done & irq_en;

    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:   readdata[WIDTH-1:0] = data_out;
            A_STATUS: readdata[2:0]       = {done, overrun, busy};
            A_CTRL:   readdata[0]         = irq_en;
            default:  readdata            = '0;
        endcase
    end

    // Upper writedata bits are ignored by design.
    logic unused_ok;
    assign unused_ok = &{1'b0, writedata};

endmodule

// File: tb/tb_lcd_pio_strobe.sv
module tb_lcd_pio_strobe;

    localparam int WIDTH = 6;
    localparam int TS    = 2;
    localparam int TP    = 12;
    localparam int TH    = 2;
    localparam int TT    = TS + TP + TH;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic             lcd_e;
    logic             irq;

    always #5 clk = ~clk;

    lcd_pio_strobe #(
        .WIDTH  (WIDTH),
        .CNT_W  (8),
        .T_SETUP(TS),
        .T_PULSE(TP),
        .T_HOLD (TH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .lcd_e     (lcd_e),
        .irq       (irq)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic             e;
        logic             irq;
    } pin_t;

    pin_t        pin_q[$];
    logic [31:0] rd_q[$];

    // Reference model: a strobe accepted at edge m_n makes the block busy
    // after edges m_n .. m_n+TT-1. lcd_e is high after edges m_n+TS .. m_n+TS+TP-1.
    // done is raised at edge m_n+TT.
    int               edge_n   = 0;
    logic [WIDTH-1:0] m_data   = '0;
    bit               m_active = 1'b0;
    int               m_n      = 0;
    bit               m_done   = 1'b0;
    bit               m_ovr    = 1'b0;
    bit               m_irq_en = 1'b0;

    function automatic bit busy_at(int k);
        return m_active && (k >= m_n) && (k < m_n + TT);
    endfunction

    function automatic bit lcd_at(int k);
        return m_active && (k >= m_n + TS) && (k < m_n + TS + TP);
    endfunction

    function automatic logic [31:0] exp_read(logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0:    r[WIDTH-1:0] = m_data;
            3'd1:    r[2:0] = {m_done, m_ovr, busy_at(edge_n)};
            3'd5:    r[0] = m_irq_en;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_edge(input logic rst, input logic cs, input logic wn,
                              input logic [2:0] a, input logic [31:0] d);
        bit wr, bp, dset, outw;
        edge_n++;
        if (rst) begin
            m_data = '0; m_active = 0; m_done = 0; m_ovr = 0; m_irq_en = 0;
            return;
        end
        wr   = cs && !wn;
        bp   = busy_at(edge_n - 1);
        dset = m_active && (edge_n == m_n + TT);
        outw = wr && (a == 3'd0 || a == 3'd2 || a == 3'd3 || a == 3'd4);
        if (outw && !bp) begin
            case (a)
                3'd0: m_data = d[WIDTH-1:0];
                3'd2: m_data = m_data | d[WIDTH-1:0];
                3'd3: m_data = m_data & ~d[WIDTH-1:0];
                3'd4: begin m_data = d[WIDTH-1:0]; m_active = 1; m_n = edge_n; end
                default: ;
            endcase
        end
        if (wr && a == 3'd1) begin
            if (d[1]) m_ovr = 0;
            if (d[2]) m_done = 0;
        end
        if (outw && bp) m_ovr = 1;
        if (dset) m_done = 1;
        if (wr && a == 3'd5) m_irq_en = d[0];
    endtask

    task automatic do_cycle(input logic rst, input logic cs, input logic wn,
                            input logic [2:0] a, input logic [31:0] d);
        pin_t p;
        reset = rst; chipselect = cs; write_n = wn; address = a; writedata = d;
        if (cs && wn) rd_q.push_back(exp_read(a));
        @(posedge clk);
        #1;
        model_edge(rst, cs, wn, a, d);
        p.out = m_data;
        p.e   = lcd_at(edge_n);
        p.irq = m_done & m_irq_en;
        pin_q.push_back(p);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        do_cycle(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        do_cycle(1'b0, 1'b1, 1'b1, a, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected pins each cycle and expected read data whenever a read is presented.
    int pulse_len = 0;
    bit rst_in_run = 0;
    always @(negedge clk) begin
        pin_t p;
        logic [31:0] er;
        if (pin_q.size() > 0) begin
            p = pin_q.pop_front();
            chk("out_port", 32'(out_port), 32'(p.out));
            chk("lcd_e", 32'(lcd_e), 32'(p.e));
            chk("irq", 32'(irq), 32'(p.irq));
        end
        if (chipselect === 1'b1 && write_n === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk("read_queue_nonempty", 32'd0, 32'd1);
            end else begin
                er = rd_q.pop_front();
                chk($sformatf("readdata@%0d", address), readdata, er);
            end
        end
        if (lcd_e === 1'b1) begin
            pulse_len++;
            if (reset === 1'b1) rst_in_run = 1;
        end else if (pulse_len > 0) begin
            if (!rst_in_run) chk("pulse_width", 32'(pulse_len), 32'(TP));
            pulse_len  = 0;
            rst_in_run = 0;
        end
    end

    initial begin
        int r;
        logic cs, wn;
        logic [2:0] a;

        // Reset, then check reset state.
        do_cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
        do_cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
        rd_reg(3'd1);
        rd_reg(3'd0);

        // DATA / OUTSET / OUTCLR.
        wr_reg(3'd0, 32'h2A);
        wr_reg(3'd2, 32'h05);
        wr_reg(3'd3, 32'h08);
        rd_reg(3'd0);
        wr_reg(3'd0, 32'hFFFF_FFC0);
        rd_reg(3'd0);

        // Full strobe with irq enabled, then clear done.
        wr_reg(3'd5, 32'h1);
        rd_reg(3'd5);
        wr_reg(3'd4, 32'h15);
        for (int i = 0; i < 8; i++) rd_reg(3'd1);
        idle(10);
        rd_reg(3'd1);
        wr_reg(3'd1, 32'h4);
        rd_reg(3'd1);

        // Overrun during PULSE.
        wr_reg(3'd4, 32'h01);
        idle(4);
        wr_reg(3'd0, 32'h3F);
        rd_reg(3'd1);
        rd_reg(3'd0);
        idle(12);
        rd_reg(3'd1);
        wr_reg(3'd1, 32'h2);
        rd_reg(3'd1);
        wr_reg(3'd1, 32'h4);

        // Reset during PULSE, then a fresh strobe.
        wr_reg(3'd4, 32'h2B);
        idle(5);
        do_cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
        rd_reg(3'd1);
        wr_reg(3'd4, 32'h33);
        idle(TT + 1);
        rd_reg(3'd1);

        // Clear-done on the same edge that HOLD completes: set wins.
        wr_reg(3'd1, 32'h4);
        wr_reg(3'd4, 32'h0A);
        idle(TT - 1);
        wr_reg(3'd1, 32'h4);
        rd_reg(3'd1);
        rd_reg(3'd6);
        rd_reg(3'd7);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 99);
            cs = ($urandom_range(0, 2) != 0);
            wn = ($urandom_range(0, 1) == 1);
            a  = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            if (r == 0) do_cycle(1'b1, cs, wn, a, $urandom);
            else if (r < 30) idle(1);
            else do_cycle(1'b0, cs, wn, a, $urandom);
        end

        idle(3);
        @(negedge clk);
        #1;
        chk("pin_queue_drained", 32'(pin_q.size()), 32'd0);
        chk("read_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
